// File: rtl/exe_pkg.sv
// Shared types for the execute stage: opcodes, access sizes, divider FSM states,
// and the byte-lane mask helper used by the store path.
// Imported by exe_stage_div and exe_div.
package exe_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_NOR  = 5'd5,
        OP_SLT  = 5'd6,
        OP_SLTU = 5'd7,
        OP_SLL  = 5'd8,
        OP_SRL  = 5'd9,
        OP_SRA  = 5'd10,
        OP_LUI  = 5'd11,
        OP_DIV  = 5'd12,
        OP_DIVU = 5'd13,
        OP_MOD  = 5'd14,
        OP_MODU = 5'd15
    } op_e;

    // Memory access size encodings
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Unshifted byte-lane enable pattern for an access size
    function automatic logic [7:0] LANE_MASK(input logic [1:0] size);
        case (size)
            SZ_B:    LANE_MASK = 8'h01;
            SZ_H:    LANE_MASK = 8'h03;
            SZ_W:    LANE_MASK = 8'h0F;
            default: LANE_MASK = 8'hFF;
        endcase
    endfunction

    function automatic logic is_div_op(input op_e op);
        is_div_op = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_MOD) || (op == OP_MODU);
    endfunction

endpackage

// File: rtl/exe_div.sv
// Iterative restoring divider, one quotient bit per cycle, for the execute stage.
// Ports: clk/rst; start/kill/ack control; is_signed, dividend, divisor operands;
// done/busy status; quotient/remainder results (valid while done).
module exe_div
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic            ack,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic            busy,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN) + 1;

    div_state_e      state;
    div_state_e      state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN-1:0] dvd_r;
    logic            neg_q;
    logic            neg_r;
    logic            dz;

    logic            dvd_neg;
    logic            dvs_neg;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] rem_sub;

    assign dvd_neg = is_signed & dividend[XLEN-1];
    assign dvs_neg = is_signed & divisor[XLEN-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;

    // Dividend magnitude shifts out of quo_r MSB-first while quotient bits shift in
    assign shifted = {rem_r, quo_r[XLEN-1]};
    assign fits    = (shifted >= {1'b0, dvs_r});
    // When the trial fits the true difference is below the divisor, so XLEN bits hold it
    assign rem_sub = shifted[XLEN-1:0] - dvs_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)               state_nxt = BUSY;
                BUSY:    if (cnt == CW'(1))       state_nxt = DONE;
                DONE:    if (ack)                 state_nxt = IDLE;
                default:                          state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        done = (state == DONE);
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            cnt   <= CW'(XLEN);
            rem_r <= '0;
            quo_r <= dvd_mag;
            dvs_r <= dvs_mag;
            dvd_r <= dividend;
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
            dz    <= (divisor == '0);
        end else if (state == BUSY) begin
            cnt   <= cnt - 1'b1;
            rem_r <= fits ? rem_sub : shifted[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], fits};
        end
    end

    // Sign fix-up; divide-by-zero overrides to all-ones quotient and the raw dividend
    assign quotient  = dz ? '1    : (neg_q ? -quo_r : quo_r);
    assign remainder = dz ? dvd_r : (neg_r ? -rem_r : rem_r);

endmodule

// File: rtl/exe_stage_div.sv
// Execute stage: single-cycle ALU, in-stage iterative divide, load/store request generation.
// Ports: ID handshake (ds_valid/es_allow_in + payload), MEM handshake (es_to_ms_valid/ms_allow_in
// + results), data_* memory request, es_busy for hazards. Macro EXE_ALE_EN enables misalignment traps.
module exe_stage_div
    import exe_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NLANE = XLEN / 8,
    localparam int OFFW  = $clog2(NLANE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ds_valid,
    output logic              es_allow_in,
    input  logic [31:0]       ds_pc,
    input  logic [4:0]        ds_op,
    input  logic [XLEN-1:0]   ds_src1,
    input  logic [XLEN-1:0]   ds_src2,
    input  logic [XLEN-1:0]   ds_rkd,
    input  logic [3:0]        ds_mem,
    input  logic              ds_ld_uns,
    input  logic [5:0]        ds_rf,
    input  logic              ms_allow_in,
    output logic              es_to_ms_valid,
    output logic [31:0]       es_pc,
    output logic [XLEN-1:0]   es_result,
    output logic [6:0]        es_rf,
    output logic [OFFW+2:0]   es_ld_info,
    output logic              es_ale,
    output logic              es_busy,
    output logic              data_en,
    output logic [NLANE-1:0]  data_we,
    output logic [XLEN-1:0]   data_addr,
    output logic [XLEN-1:0]   data_wdata
);

    logic            es_valid;
    op_e             es_op;
    logic [XLEN-1:0] es_src1;
    logic [XLEN-1:0] es_src2;
    logic [XLEN-1:0] es_rkd;
    logic [3:0]      es_mem;
    logic            es_ld_uns;
    logic [5:0]      es_rf_r;

    logic            ready_go;
    logic            is_ld;
    logic            is_st;
    logic            is_mem;
    logic            is_div;
    logic [1:0]      size;
    logic [XLEN-1:0] addr;
    logic [OFFW-1:0] off;
    logic [OFFW+2:0] sa;
    logic [XLEN-1:0] alu_res;
    logic [NLANE-1:0] lane_mask;

    logic            div_done;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            es_valid <= 1'b0;
        end else if (es_allow_in) begin
            es_valid <= ds_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ds_valid && es_allow_in) begin
            es_pc     <= ds_pc;
            es_op     <= op_e'(ds_op);
            es_src1   <= ds_src1;
            es_src2   <= ds_src2;
            es_rkd    <= ds_rkd;
            es_mem    <= ds_mem;
            es_ld_uns <= ds_ld_uns;
            es_rf_r   <= ds_rf;
        end
    end

    assign is_ld  = es_mem[3];
    assign is_st  = es_mem[2];
    assign is_mem = is_ld | is_st;
    assign is_div = is_div_op(es_op);
    // A doubleword request on a 32-bit datapath degrades to a word access
    assign size   = (XLEN == 32 && es_mem[1:0] == SZ_D) ? SZ_W : es_mem[1:0];
    assign addr   = es_src1 + es_src2;
    assign off    = addr[OFFW-1:0];
    assign sa     = es_src2[OFFW+2:0];

    assign ready_go       = is_div ? div_done : 1'b1;
    assign es_allow_in    = ~es_valid | (ready_go & ms_allow_in);
    assign es_to_ms_valid = es_valid & ready_go & ~flush;

    exe_div #(
        .XLEN(XLEN)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (es_valid & is_div),
        .kill      (flush),
        .ack       (es_allow_in),
        .is_signed ((es_op == OP_DIV) || (es_op == OP_MOD)),
        .dividend  (es_src1),
        .divisor   (es_src2),
        .done      (div_done),
        .busy      (es_busy),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        alu_res = '0;
        case (es_op)
            OP_ADD:  alu_res = es_src1 + es_src2;
            OP_SUB:  alu_res = es_src1 - es_src2;
            OP_AND:  alu_res = es_src1 & es_src2;
            OP_OR:   alu_res = es_src1 | es_src2;
            OP_XOR:  alu_res = es_src1 ^ es_src2;
            OP_NOR:  alu_res = ~(es_src1 | es_src2);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(es_src1) < $signed(es_src2))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (es_src1 < es_src2)};
            OP_SLL:  alu_res = es_src1 << sa;
            OP_SRL:  alu_res = es_src1 >> sa;
            OP_SRA:  alu_res = $signed(es_src1) >>> sa;
            OP_LUI:  alu_res = es_src2;  // decode supplies the already-positioned immediate
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        if (is_div) begin
            es_result = (es_op == OP_DIV || es_op == OP_DIVU) ? div_quo : div_rem;
        end else if (is_mem) begin
            es_result = addr;
        end else begin
            es_result = alu_res;
        end
    end

`ifdef EXE_ALE_EN
    logic misaligned;
    always_comb begin
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr[0];
            SZ_W:    misaligned = |addr[1:0];
            default: misaligned = |addr[2:0];
        endcase
    end
    assign es_ale = es_valid & is_mem & misaligned;
`else
    assign es_ale = 1'b0;
`endif

    assign lane_mask = NLANE'(LANE_MASK(size));

    assign data_en   = es_valid & is_mem & ~es_ale & ms_allow_in & ~flush;
    // Lanes pushed past the top of the bus by a misaligned offset are simply dropped
    assign data_we   = (es_valid & is_st & ~es_ale) ? (lane_mask << off) : '0;
    assign data_addr = addr;

    always_comb begin
        case (size)
            SZ_B:    data_wdata = {NLANE{es_rkd[7:0]}};
            SZ_H:    data_wdata = {(NLANE/2){es_rkd[15:0]}};
            SZ_W:    data_wdata = {(XLEN/32){es_rkd[31:0]}};
            default: data_wdata = es_rkd;
        endcase
    end

    assign es_rf      = es_valid ? {is_ld, es_rf_r[5] & ~es_ale, es_rf_r[4:0]} : 7'd0;
    assign es_ld_info = {off, es_ld_uns, size};

endmodule

// File: doc/exe_stage_div.md
Name: exe_stage_div

Overview:
Parametrised execute stage for the in-order pipelined CPU, sitting between decode (ID) and memory (MEM) with valid/allow_in handshakes on both sides.
- Single-cycle integer ALU ops.
- Iterative signed/unsigned divide/modulo held in-stage by an FSM.
- Store/load request generation with byte-lane enables generalised to XLEN.
- Pipeline flush and address-misalignment detection.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
NLANE, XLEN/8, byte lanes on the data interface (derived, not overridable).
OFFW, $clog2(NLANE), address offset bits used for lane selection (derived).

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  kill the in-stage instruction and abort any divide
ds_valid  in  1  ID has an instruction for EXE
es_allow_in  out  1  EXE accepts this cycle
ds_pc  in  32  instruction PC
ds_op  in  5  operation code (exe_pkg::op_e)
ds_src1  in  XLEN  operand 1 / base address
ds_src2  in  XLEN  operand 2 / offset
ds_rkd  in  XLEN  store data
ds_mem  in  4  {is_ld, is_st, size[1:0]}; size: 0=B, 1=H, 2=W, 3=D
ds_ld_uns  in  1  zero-extending load
ds_rf  in  6  {rf_we, rf_waddr[4:0]}
ms_allow_in  in  1  MEM accepts
es_to_ms_valid  out  1  EXE result valid toward MEM
es_pc  out  32  latched PC
es_result  out  XLEN  ALU/divider result or effective address
es_rf  out  7  {res_from_mem, rf_we, rf_waddr}, all gated by es_valid
es_ld_info  out  OFFW+3  {addr[OFFW-1:0], ld_uns, size}
es_ale  out  1  misaligned access flag, gated by es_valid
es_busy  out  1  divider FSM not IDLE (hazard unit)
data_en  out  1  memory request
data_we  out  NLANE  byte write enables
data_addr  out  XLEN  request address
data_wdata  out  XLEN  replicated store data

Behaviour:
- rst (synchronous, active-high) on clk:
  - es_valid=0, FSM=IDLE.
  - All valid-gated outputs, data_en, data_we and es_busy are 0.
  - Payload registers are unreset.
- Latch payload when ds_valid & es_allow_in.
- es_valid update order, highest priority first:
  - rst or flush: es_valid<=0.
  - Else if es_allow_in: es_valid<=ds_valid.
- es_allow_in = ~es_valid | (ready_go & ms_allow_in).
- es_to_ms_valid = es_valid & ready_go & ~flush.
- ready_go:
  - Non-divide ops: 1.
  - Divide ops: 1 only in FSM state DONE.
- ALU ops: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI.
  - Shift amount is src2[OFFW+2:0].
  - Result is combinational from latched operands; zero-latency stage.
- Divider ops: DIV, DIVU, MOD, MODU. Restoring algorithm, one quotient bit per cycle.
  - FSM: IDLE -> BUSY on the first cycle es_valid & div-op. Operands are converted to magnitude in that cycle; counter=XLEN.
  - BUSY: counter decrements each cycle; -> DONE when counter reaches 1.
  - DONE: applies sign fix and holds the result until es_allow_in, then -> IDLE.
  - Latency: ready_go rises exactly XLEN+1 cycles after the instruction is latched.
  - Back-to-back divides re-enter BUSY the cycle after DONE->IDLE.
- Divide boundary cases:
  - Divide by zero: quotient = all ones, remainder = dividend (signed and unsigned).
  - Signed MIN / -1: quotient = MIN, remainder = 0.
  - Sign rules: remainder takes the dividend's sign; quotient is negated when operand signs differ.
- flush or rst during BUSY/DONE: FSM -> IDLE next cycle, no result emitted, es_busy=0 next cycle.
- flush in the same cycle as ds_valid: the incoming instruction is discarded.
- Memory:
  - Address = src1 + src2.
  - data_en = es_valid & (is_ld | is_st) & ~es_ale & ms_allow_in & ~flush; one request, issued in the hand-off cycle.
  - data_we = lane mask shifted by addr[OFFW-1:0], only for stores, else 0.
  - Lane masks: B=1, H=3, W=0xF, D=0xFF.
  - data_wdata: B/H/W data replicated across NLANE.
  - size=3 with XLEN=32 is treated as W.
- es_ld_info carries alignment and extension info for MEM-stage load formatting.

Optional Feature:
Macro EXE_ALE_EN.
- Defined:
  - es_ale = es_valid & mem-op & (addr mod access size != 0).
  - When es_ale: data_en=0, data_we=0, and es_rf rf_we is forced 0.
- Undefined:
  - es_ale tied 0.
  - Low address bits used unmodified; a misaligned halfword at offset 3 produces mask 4'b1000 truncated by the shift.

Decomposition:
- Package exe_pkg:
  - op_e enum (5-bit) and size encodings.
  - div_state_e {IDLE, BUSY, DONE}.
  - LANE_MASK function.
- Sub-module exe_div, instantiated once:
  - Contains the FSM, counter, sign handling and divide-by-zero override.
  - Interface: start/kill/ack in; done/quotient/remainder out.

Test Plan:
- ADD 5+7, ms_allow_in=1 -> es_to_ms_valid the cycle after latch, es_result=12, es_rf rf_we=1.
- DIV -7/2, XLEN=32 -> ready_go low for 32 cycles, high at cycle 33; quotient=-3, remainder (MOD)=-1; es_busy low after hand-off.
- DIVU 100/0 -> quotient 0xFFFFFFFF; MODU 100/0 -> 100; DIV 0x80000000/-1 -> 0x80000000, MOD -> 0.
- ST.B to addr 0x1003 with data 0xAB -> data_we=4'b1000, data_wdata=0xABABABAB, data_en for 1 cycle. With XLEN=64 ST.W to 0x...4 -> data_we=8'hF0.
- Divide in BUSY at cycle 10, flush asserted -> es_valid=0, FSM IDLE next cycle, no es_to_ms_valid. A new ADD accepted the following cycle completes normally.
- EXE_ALE_EN defined, LD.W at 0x2002 -> es_ale=1, data_en=0, rf_we=0. Same access without the macro -> data_en=1, es_ale=0.
